rom_rd_return: RTL



---
 rtl/rom_rd_return.sv | 102 ++++++++++
 1 files changed

// File: rtl/rom_rd_return.sv
// rtl/rom_rd_return.sv - shared sprite-ROM read port for the bullet and player pixel fetchers
// Arbitrates both clients onto one registered ROM address and steers returned words by tag.
module rom_rd_return #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 12,
  parameter int ROM_LAT    = 2,
  parameter int MAX_STREAK = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              blt_req,
  input  logic [ADDR_W-1:0] blt_addr,
  output logic              blt_gnt,
  output logic [DATA_W-1:0] blt_data,
  output logic              blt_vld,
  input  logic              me_req,
  input  logic [ADDR_W-1:0] me_addr,
  output logic              me_gnt,
  output logic [DATA_W-1:0] me_data,
  output logic              me_vld,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              busy
);

  localparam int DEPTH = ROM_LAT + 1;
  localparam logic [2:0] MAX_S = 3'(MAX_STREAK);

  logic [2:0]        streak_q, streak_d;
  logic [DEPTH-1:0]  tag_vld_q, tag_vld_d;
  logic [DEPTH-1:0]  tag_src_q, tag_src_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0] blt_data_q, blt_data_d;
  logic [DATA_W-1:0] me_data_q, me_data_d;
  logic              blt_vld_q, blt_vld_d;
  logic              me_vld_q, me_vld_d;
  logic              me_turn;
  logic              ret_vld;
  logic              ret_src;

  always_comb begin
    // Bullet wins ties until it has used up its streak allowance against a waiting player.
    me_turn = (streak_q == MAX_S);
    blt_gnt = blt_req & ~(me_req & me_turn);
    me_gnt  = me_req & (~blt_req | me_turn);

    streak_d = streak_q;
    if (!me_req || me_gnt) begin
      streak_d = 3'd0;
    end else if (blt_gnt) begin
      streak_d = streak_q + 3'd1;
    end

    rom_addr_d = rom_addr_q;
    if (blt_gnt) begin
      rom_addr_d = blt_addr;
    end else if (me_gnt) begin
      rom_addr_d = me_addr;
    end

    // src bit: 0 = bullet, 1 = player; the last stage lines up with valid rom_dout.
    tag_vld_d = {tag_vld_q[DEPTH-2:0], blt_gnt | me_gnt};
    tag_src_d = {tag_src_q[DEPTH-2:0], me_gnt};
    ret_vld   = tag_vld_q[DEPTH-1];
    ret_src   = tag_src_q[DEPTH-1];

    blt_vld_d  = ret_vld & ~ret_src;
    me_vld_d   = ret_vld & ret_src;
    blt_data_d = blt_vld_d ? rom_dout : blt_data_q;
    me_data_d  = me_vld_d ? rom_dout : me_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q   <= '0;
      tag_vld_q  <= '0;
      tag_src_q  <= '0;
      rom_addr_q <= '0;
      blt_data_q <= '0;
      me_data_q  <= '0;
      blt_vld_q  <= 1'b0;
      me_vld_q   <= 1'b0;
    end else begin
      streak_q   <= streak_d;
      tag_vld_q  <= tag_vld_d;
      tag_src_q  <= tag_src_d;
      rom_addr_q <= rom_addr_d;
      blt_data_q <= blt_data_d;
      me_data_q  <= me_data_d;
      blt_vld_q  <= blt_vld_d;
      me_vld_q   <= me_vld_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign blt_data = blt_data_q;
  assign me_data  = me_data_q;
  assign blt_vld  = blt_vld_q;
  assign me_vld   = me_vld_q;
  assign busy     = |tag_vld_q;

endmodule
